frame_sequencer: RTL and testbench

//  Per-frame control stage directly upstream of the geometry pipeline. Owns the

---
 rtl/frame_sequencer_if.sv | 28 ++
 rtl/frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_frame_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// Handshake and status bundle between the frame sequencer and its neighbours
// (framebuffer ready flag, matrix generator, vertex fetch, statistics display).
interface frame_sequencer_if #(
  parameter int COUNT_W = 16
);
  logic               framebuffer_ready_in;
  logic               matrix_done_in;
  logic               pixel_valid_in;
  logic               fb_switch_out;
  logic               fb_clear_out;
  logic               matrix_start_out;
  logic               fetch_rst_out;
  logic [COUNT_W-1:0] frame_count_out;
  logic [COUNT_W-1:0] pixel_count_out;
  logic [COUNT_W-1:0] skip_count_out;

  modport master (
    output framebuffer_ready_in, matrix_done_in, pixel_valid_in,
    input  fb_switch_out, fb_clear_out, matrix_start_out, fetch_rst_out,
    input  frame_count_out, pixel_count_out, skip_count_out
  );

  modport slave (
    input  framebuffer_ready_in, matrix_done_in, pixel_valid_in,
    output fb_switch_out, fb_clear_out, matrix_start_out, fetch_rst_out,
    output frame_count_out, pixel_count_out, skip_count_out
  );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame control stage ahead of the geometry pipeline: render period timer,
// buffer switch/clear pulses, matrix kick, vertex-fetch reset and frame statistics.
module frame_sequencer #(
  parameter int FRAME_PERIOD = 2_000_000,
  parameter int COUNT_W      = 16
) (
  input  logic           clk_in,
  input  logic           rst_in,
  frame_sequencer_if.slave seq
);

  localparam int TIMER_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_DRAIN      = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_MATRIX     = 2'd2,
    ST_RUN        = 2'd3
  } state_t;

  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] value,
                                                 input logic              inc);
    if (inc && (value != {COUNT_W{1'b1}})) begin
      return value + COUNT_W'(1);
    end else begin
      return value;
    end
  endfunction

  state_t             state_r;
  logic [TIMER_W-1:0] timer_r;
  logic               fb_switch_r;
  logic               fb_clear_r;
  logic               matrix_start_r;
  logic               fetch_rst_r;
  logic [COUNT_W-1:0] acc_r;
  logic [COUNT_W-1:0] frame_count_r;
  logic [COUNT_W-1:0] pixel_count_r;
  logic [COUNT_W-1:0] skip_count_r;
  logic               wrap_s;
  logic [COUNT_W-1:0] acc_next_s;

  assign wrap_s     = (timer_r == TIMER_LAST);
  assign acc_next_s = sat_add(acc_r, seq.pixel_valid_in);

  // Free-running period timer, switch/clear pulses and skipped-period count.
  // The skip test uses the pre-update state, so a RUN exit on the wrap edge is not a skip.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      timer_r      <= '0;
      fb_switch_r  <= 1'b0;
      fb_clear_r   <= 1'b1;
      skip_count_r <= '0;
    end else begin
      if (wrap_s) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TIMER_W'(1);
      end
      fb_switch_r <= wrap_s;
      fb_clear_r  <= wrap_s;
      if (wrap_s && (state_r != ST_RUN)) begin
        skip_count_r <= skip_count_r + COUNT_W'(1);
      end else begin
        skip_count_r <= skip_count_r;
      end
    end
  end

  // Frame FSM with registered matrix kick, fetch reset and frame statistics.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r        <= ST_DRAIN;
      matrix_start_r <= 1'b0;
      fetch_rst_r    <= 1'b1;
      acc_r          <= '0;
      frame_count_r  <= '0;
      pixel_count_r  <= '0;
    end else begin
      matrix_start_r <= 1'b0;
      case (state_r)
        ST_DRAIN: begin
          fetch_rst_r <= 1'b1;
          if (!seq.framebuffer_ready_in) begin
            state_r <= ST_WAIT_READY;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_WAIT_READY: begin
          fetch_rst_r <= 1'b1;
          if (seq.framebuffer_ready_in) begin
            state_r        <= ST_MATRIX;
            matrix_start_r <= 1'b1;
          end else begin
            state_r <= ST_WAIT_READY;
          end
        end
        ST_MATRIX: begin
          // Losing the buffer aborts the build even if the matrix lands the same cycle.
          if (!seq.framebuffer_ready_in) begin
            state_r     <= ST_WAIT_READY;
            fetch_rst_r <= 1'b1;
          end else if (seq.matrix_done_in) begin
            state_r     <= ST_RUN;
            fetch_rst_r <= 1'b0;
            acc_r       <= '0;
          end else begin
            state_r     <= ST_MATRIX;
            fetch_rst_r <= 1'b1;
          end
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          if (!seq.framebuffer_ready_in) begin
            state_r       <= ST_WAIT_READY;
            fetch_rst_r   <= 1'b1;
            pixel_count_r <= acc_next_s;
            frame_count_r <= frame_count_r + COUNT_W'(1);
          end else begin
            state_r     <= ST_RUN;
            fetch_rst_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_DRAIN;
          fetch_rst_r <= 1'b1;
        end
      endcase
    end
  end

  assign seq.fb_switch_out    = fb_switch_r;
  assign seq.fb_clear_out     = fb_clear_r;
  assign seq.matrix_start_out = matrix_start_r;
  assign seq.fetch_rst_out    = fetch_rst_r;
  assign seq.frame_count_out  = frame_count_r;
  assign seq.pixel_count_out  = pixel_count_r;
  assign seq.skip_count_out   = skip_count_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with FRAME_PERIOD=100; expected values are hand-derived.
module tb_frame_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   starts;
  int   low_cnt;

  frame_sequencer_if #(.COUNT_W(16)) bus ();

  frame_sequencer #(
    .FRAME_PERIOD(100),
    .COUNT_W     (16)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .seq   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.matrix_start_out === 1'b1) starts++;
    if (bus.fetch_rst_out === 1'b0) low_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    starts = 0;
    low_cnt = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    starts = 0;
    low_cnt = 0;
    rst = 1'b1;
    bus.framebuffer_ready_in = 1'b1;
    bus.matrix_done_in = 1'b0;
    bus.pixel_valid_in = 1'b0;

    // Reset values
    #2;
    check("rst_fb_clear", {31'd0, bus.fb_clear_out}, 32'd1);
    check("rst_fb_switch", {31'd0, bus.fb_switch_out}, 32'd0);
    check("rst_fetch_rst", {31'd0, bus.fetch_rst_out}, 32'd1);
    check("rst_matrix_start", {31'd0, bus.matrix_start_out}, 32'd0);
    check("rst_frame_count", {16'd0, bus.frame_count_out}, 32'd0);
    check("rst_pixel_count", {16'd0, bus.pixel_count_out}, 32'd0);
    check("rst_skip_count", {16'd0, bus.skip_count_out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Timer pulses with ready held high: FSM parks in DRAIN
    for (int k = 1; k <= 300; k++) begin
      tick();
      check("timer_switch", {31'd0, bus.fb_switch_out}, (cyc % 100 == 0) ? 32'd1 : 32'd0);
      check("timer_clear", {31'd0, bus.fb_clear_out}, (cyc % 100 == 0) ? 32'd1 : 32'd0);
      check("drain_fetch_rst", {31'd0, bus.fetch_rst_out}, 32'd1);
    end
    check("drain_no_start", starts, 32'd0);
    check("drain_skip_count", {16'd0, bus.skip_count_out}, 32'd3);

    // Full frame, ending on the wrap edge (cycle 100): no skip counted
    bus.framebuffer_ready_in = 1'b0;
    do_reset();
    tick();
    bus.framebuffer_ready_in = 1'b1;
    tick();
    check("ff_start_pulse", {31'd0, bus.matrix_start_out}, 32'd1);
    check("ff_fetch_rst_matrix", {31'd0, bus.fetch_rst_out}, 32'd1);
    tick();
    check("ff_start_one_cycle", {31'd0, bus.matrix_start_out}, 32'd0);
    tick();
    bus.matrix_done_in = 1'b1;
    tick();
    bus.matrix_done_in = 1'b0;
    check("ff_fetch_rst_low", {31'd0, bus.fetch_rst_out}, 32'd0);
    bus.pixel_valid_in = 1'b1;
    repeat (37) tick();
    bus.pixel_valid_in = 1'b0;
    check("ff_pixel_before_end", {16'd0, bus.pixel_count_out}, 32'd0);
    while (cyc < 99) tick();
    bus.framebuffer_ready_in = 1'b0;
    tick();
    check("ff_switch_at_exit", {31'd0, bus.fb_switch_out}, 32'd1);
    check("ff_pixel_count", {16'd0, bus.pixel_count_out}, 32'd37);
    check("ff_frame_count", {16'd0, bus.frame_count_out}, 32'd1);
    check("ff_fetch_rst_high", {31'd0, bus.fetch_rst_out}, 32'd1);
    check("ff_no_skip_on_exit", {16'd0, bus.skip_count_out}, 32'd0);
    check("ff_one_start", starts, 32'd1);
    check("ff_low_len_ge_38", (low_cnt >= 38) ? 32'd1 : 32'd0, 32'd1);

    // Pixel coinciding with ready fall is counted
    bus.framebuffer_ready_in = 1'b1;
    tick();
    bus.matrix_done_in = 1'b1;
    tick();
    bus.matrix_done_in = 1'b0;
    bus.pixel_valid_in = 1'b1;
    repeat (37) tick();
    bus.framebuffer_ready_in = 1'b0;
    tick();
    bus.pixel_valid_in = 1'b0;
    check("same_cycle_pixel_count", {16'd0, bus.pixel_count_out}, 32'd38);
    check("same_cycle_frame_count", {16'd0, bus.frame_count_out}, 32'd2);

    // Abort in MATRIX (done same cycle as ready fall), stray pixels/done ignored
    bus.pixel_valid_in = 1'b1;
    tick();
    bus.framebuffer_ready_in = 1'b1;
    tick();
    tick();
    bus.framebuffer_ready_in = 1'b0;
    bus.matrix_done_in = 1'b1;
    tick();
    bus.pixel_valid_in = 1'b0;
    check("abort_fetch_rst", {31'd0, bus.fetch_rst_out}, 32'd1);
    check("abort_frame_count", {16'd0, bus.frame_count_out}, 32'd2);
    tick();
    bus.matrix_done_in = 1'b0;
    check("done_ignored_wait", {31'd0, bus.fetch_rst_out}, 32'd1);
    bus.framebuffer_ready_in = 1'b1;
    tick();
    check("abort_restart_pulse", {31'd0, bus.matrix_start_out}, 32'd1);
    bus.matrix_done_in = 1'b1;
    tick();
    bus.matrix_done_in = 1'b0;
    check("abort_run_fetch_low", {31'd0, bus.fetch_rst_out}, 32'd0);
    tick();
    bus.framebuffer_ready_in = 1'b0;
    tick();
    check("empty_frame_pixels", {16'd0, bus.pixel_count_out}, 32'd0);
    check("empty_frame_count", {16'd0, bus.frame_count_out}, 32'd3);
    while (cyc < 200) tick();
    check("wait_skip_at_200", {16'd0, bus.skip_count_out}, 32'd1);

    // Asynchronous reset while in RUN
    bus.framebuffer_ready_in = 1'b1;
    tick();
    bus.matrix_done_in = 1'b1;
    tick();
    bus.matrix_done_in = 1'b0;
    bus.pixel_valid_in = 1'b1;
    tick();
    tick();
    check("pre_reset_in_run", {31'd0, bus.fetch_rst_out}, 32'd0);
    rst = 1'b1;
    #2;
    check("async_fetch_rst", {31'd0, bus.fetch_rst_out}, 32'd1);
    check("async_fb_clear", {31'd0, bus.fb_clear_out}, 32'd1);
    check("async_frame_count", {16'd0, bus.frame_count_out}, 32'd0);
    check("async_pixel_count", {16'd0, bus.pixel_count_out}, 32'd0);
    check("async_skip_count", {16'd0, bus.skip_count_out}, 32'd0);
    check("async_matrix_start", {31'd0, bus.matrix_start_out}, 32'd0);
    bus.pixel_valid_in = 1'b0;
    bus.framebuffer_ready_in = 1'b0;
    do_reset();

    // Three periods without ready
    repeat (300) tick();
    check("idle_skip_count", {16'd0, bus.skip_count_out}, 32'd3);
    check("idle_frame_count", {16'd0, bus.frame_count_out}, 32'd0);
    check("idle_fetch_rst", {31'd0, bus.fetch_rst_out}, 32'd1);

    // Saturating pixel count
    bus.framebuffer_ready_in = 1'b1;
    tick();
    bus.matrix_done_in = 1'b1;
    tick();
    bus.matrix_done_in = 1'b0;
    bus.pixel_valid_in = 1'b1;
    repeat (70000) tick();
    bus.framebuffer_ready_in = 1'b0;
    tick();
    bus.pixel_valid_in = 1'b0;
    check("sat_pixel_count", {16'd0, bus.pixel_count_out}, 32'd65535);
    check("sat_frame_count", {16'd0, bus.frame_count_out}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
